rv_mc_ctrl: RTL and testbench

- Multicycle RV32I control FSM that drives the shared 32-bit ALU's 4-bit ctrl code and operand selects, and consumes its 4-bit flags for branch resolution.
- Sequences fetch / decode / execute / memory / writeback.
- Issues req/ready memory handshakes.
- Asserts register-file, PC and IR write strobes for the datapath.

---
 rtl/rv_mc_pkg.sv | 58 +++++
 rtl/rv_alu_dec.sv | 25 ++
 rtl/rv_mc_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rv_mc_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rv_mc_pkg.sv
// rv_mc_pkg: shared encodings for the multicycle RV32I control FSM and its ALU decode.
package rv_mc_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_JALR = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b1111;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // All 16 codes are used, so LUI and AUIPC share S_UIMM and pick a_sel from the latched opcode.
    typedef logic [3:0] state_t;
    localparam state_t S_RST   = 4'd0;
    localparam state_t S_FETCH = 4'd1;
    localparam state_t S_DEC   = 4'd2;
    localparam state_t S_EXR   = 4'd3;
    localparam state_t S_EXI   = 4'd4;
    localparam state_t S_WBA   = 4'd5;
    localparam state_t S_MADR  = 4'd6;
    localparam state_t S_MRD   = 4'd7;
    localparam state_t S_WBM   = 4'd8;
    localparam state_t S_MWR   = 4'd9;
    localparam state_t S_BR    = 4'd10;
    localparam state_t S_JAL   = 4'd11;
    localparam state_t S_JALR  = 4'd12;
    localparam state_t S_JWB   = 4'd13;
    localparam state_t S_UIMM  = 4'd14;
    localparam state_t S_TRAP  = 4'd15;

    localparam logic [1:0] A_RS1   = 2'd0;
    localparam logic [1:0] A_PC    = 2'd1;
    localparam logic [1:0] A_OLDPC = 2'd2;
    localparam logic [1:0] A_ZERO  = 2'd3;

    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

endpackage

// File: rtl/rv_alu_dec.sv
// rv_alu_dec: funct3/funct7b5 to ALU ctrl for register and immediate arithmetic.
module rv_alu_dec
    import rv_mc_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       is_rtype_i,
    output logic [3:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (funct3_i)
            3'b000: alu_ctrl_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b001: alu_ctrl_o = ALU_SLL;
            3'b010: alu_ctrl_o = ALU_SLT;
            3'b011: alu_ctrl_o = ALU_SLTU;
            3'b100: alu_ctrl_o = ALU_XOR;
            3'b101: alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
            3'b110: alu_ctrl_o = ALU_OR;
            default: alu_ctrl_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/rv_mc_ctrl.sv
// rv_mc_ctrl: multicycle RV32I control FSM driving ALU selects, memory handshake and datapath strobes.
module rv_mc_ctrl
    import rv_mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  a_sel,
    output logic [1:0]  b_sel,
    output logic        pc_src,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        illegal,
    output logic [3:0]  busy_state
);

    localparam bit             TO_EN  = WAIT_LIMIT > 0;
    localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(WAIT_LIMIT > 0 ? WAIT_LIMIT - 1 : 0);

    state_t           state_q, state_d;
    logic [6:0]       opcode_q;
    logic [2:0]       funct3_q;
    logic             funct7b5_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dec_ctrl, br_ctrl;
    logic             mem_st, timeout, br_bad, br_taken;
    logic             unused_bits;

    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], alu_flags[3:1]};

    rv_alu_dec u_alu_dec (
        .funct3_i   (funct3_q),
        .funct7b5_i (funct7b5_q),
        .is_rtype_i (opcode_q == OP_R),
        .alu_ctrl_o (dec_ctrl)
    );

    // A timeout fires on the WAIT_LIMIT-th consecutive stalled cycle unless mem_ready arrives in it.
    assign mem_st  = state_q inside {S_FETCH, S_MRD, S_MWR};
    assign timeout = TO_EN && mem_st && !mem_ready && (cnt_q >= LIM_M1);
    assign cnt_d   = (mem_st && !mem_ready) ? ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1)) : '0;

    // Inverting zero for BNE/BLT/BLTU falls out of funct3[2]^funct3[0].
    assign br_bad   = funct3_q[2:1] == 2'b01;
    assign br_ctrl  = !funct3_q[2] ? ALU_SUB : (funct3_q[1] ? ALU_SLTU : ALU_SLT);
    assign br_taken = !br_bad && (alu_flags[0] ^ funct3_q[2] ^ funct3_q[0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: state_d = timeout ? S_TRAP : (mem_ready ? S_DEC : S_FETCH);
            S_DEC: begin
                case (opcode_q)
                    OP_R:              state_d = S_EXR;
                    OP_I:              state_d = S_EXI;
                    OP_LOAD, OP_STORE: state_d = S_MADR;
                    OP_BR:             state_d = S_BR;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UIMM;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_EXR, S_EXI, S_UIMM:        state_d = S_WBA;
            S_WBA, S_WBM, S_JAL, S_JWB:  state_d = S_FETCH;
            S_MADR:  state_d = (opcode_q == OP_LOAD) ? S_MRD : S_MWR;
            S_MRD:   state_d = timeout ? S_TRAP : (mem_ready ? S_WBM : S_MRD);
            S_MWR:   state_d = timeout ? S_TRAP : (mem_ready ? S_FETCH : S_MWR);
            S_BR:    state_d = br_bad ? S_TRAP : S_FETCH;
            S_JALR:  state_d = S_JWB;
            default: state_d = S_TRAP;
        endcase
    end

    always_comb begin
        alu_ctrl     = ALU_ADD;
        a_sel        = A_RS1;
        b_sel        = B_RS2;
        pc_src       = 1'b0;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        illegal      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                a_sel    = A_PC;
                b_sel    = B_FOUR;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DEC: begin
                a_sel = A_OLDPC;
                b_sel = B_IMM;
            end
            S_EXR:  alu_ctrl = dec_ctrl;
            S_EXI: begin
                alu_ctrl = dec_ctrl;
                b_sel    = B_IMM;
            end
            S_WBA:  reg_write = 1'b1;
            S_MADR: b_sel = B_IMM;
            S_MRD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
            end
            S_WBM: begin
                reg_write = 1'b1;
                wb_sel    = WB_MEM;
            end
            S_MWR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
            end
            S_BR: begin
                alu_ctrl = br_ctrl;
                pc_src   = 1'b1;
                pc_write = br_taken;
            end
            S_JAL, S_JWB: begin
                reg_write = 1'b1;
                wb_sel    = WB_PC;
                pc_write  = 1'b1;
                pc_src    = 1'b1;
            end
            S_JALR: begin
                alu_ctrl = ALU_JALR;
                b_sel    = B_IMM;
            end
            S_UIMM: begin
                a_sel = (opcode_q == OP_LUI) ? A_ZERO : A_OLDPC;
                b_sel = B_IMM;
            end
            S_TRAP: illegal = 1'b1;
            default: ;
        endcase
    end

    assign busy_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RST;
            cnt_q      <= '0;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ir_write) begin
                opcode_q   <= instr[6:0];
                funct3_q   <= instr[14:12];
                funct7b5_q <= instr[30];
            end
        end
    end

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// tb_rv_mc_ctrl: table-driven per-cycle checks of rv_mc_ctrl plus reset corner sequences.
module tb_rv_mc_ctrl;

    localparam int ST_RST = 0, ST_F = 1, ST_D = 2, ST_EXR = 3, ST_EXI = 4, ST_WBA = 5;
    localparam int ST_MADR = 6, ST_MRD = 7, ST_WBM = 8, ST_MWR = 9, ST_BR = 10, ST_JAL = 11;
    localparam int ST_JALR = 12, ST_JWB = 13, ST_UIMM = 14, ST_TRAP = 15;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_SRAI  = 32'h4020D193;
    localparam logic [31:0] I_ADDIN = 32'hC0000093;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_BLT   = 32'h0020C463;
    localparam logic [31:0] I_BGEU  = 32'h0020F463;
    localparam logic [31:0] I_BBAD  = 32'h0020A463;
    localparam logic [31:0] I_LW    = 32'h0000A183;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_JAL   = 32'h010000EF;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_AUIPC = 32'h12345297;
    localparam logic [31:0] I_ILL   = 32'h00000000;

    // strobe string order: illegal pc_src pc_write ir_write reg_write mem_req mem_we mem_addr_sel; '-' = don't care
    localparam string SN = "0-0000--";

    typedef struct {
        bit          r;
        logic [31:0] i;
        bit          rdy;
        logic [3:0]  fl;
        int          st, ctrl, a, b, wb;
        string       s;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic [3:0]  alu_flags = '0;
    logic [3:0]  alu_ctrl, busy_state;
    logic [1:0]  a_sel, b_sel, wb_sel;
    logic        pc_src, pc_write, ir_write, reg_write, mem_req, mem_we, mem_addr_sel, illegal;

    int   n_run = 0, n_fail = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    rv_mc_ctrl #(.WAIT_LIMIT(5), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_flags(alu_flags),
        .alu_ctrl(alu_ctrl), .a_sel(a_sel), .b_sel(b_sel), .pc_src(pc_src), .pc_write(pc_write),
        .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .illegal(illegal), .busy_state(busy_state)
    );

    function automatic logic [7:0] strobes();
        return {illegal, pc_src, pc_write, ir_write, reg_write, mem_req, mem_we, mem_addr_sel};
    endfunction

    function automatic bit match(input vec_t v);
        logic [7:0] g;
        g = strobes();
        match = (busy_state == 4'(v.st)) && (v.ctrl < 0 || alu_ctrl == 4'(v.ctrl)) &&
                (v.a < 0 || a_sel == 2'(v.a)) && (v.b < 0 || b_sel == 2'(v.b)) &&
                (v.wb < 0 || wb_sel == 2'(v.wb));
        for (int j = 0; j < 8; j++)
            if (v.s[j] != "-" && g[7-j] != (v.s[j] == "1")) match = 1'b0;
    endfunction

    task automatic add_v(input bit r, input logic [31:0] i, input bit rdy, input logic [3:0] fl,
                         input int st, input int ctrl, input int a, input int b, input int wb,
                         input string s);
        tv.push_back('{r, i, rdy, fl, st, ctrl, a, b, wb, s});
    endtask

    task automatic fd(input logic [31:0] i, input logic [3:0] fl);
        add_v(1, i, 1, fl, ST_F, 0, 1, 2, -1, "00110100");
        add_v(1, i, 1, fl, ST_D, 0, 2, 1, -1, SN);
    endtask

    task automatic wba(input logic [31:0] i);
        add_v(1, i, 1, 0, ST_WBA, -1, -1, -1, 0, "0-0010--");
    endtask

    task automatic rsts(input logic [31:0] i);
        add_v(0, i, 1, 0, ST_RST, 0, 0, 0, 0, "00000000");
        add_v(1, i, 1, 0, ST_RST, 0, 0, 0, 0, "00000000");
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        rsts(I_ADD);
        fd(I_ADD, 0);   add_v(1, I_ADD, 1, 0, ST_EXR, 0, 0, 0, -1, SN);     wba(I_ADD);
        fd(I_SUB, 0);   add_v(1, I_SUB, 1, 0, ST_EXR, 1, 0, 0, -1, SN);     wba(I_SUB);
        fd(I_SRAI, 0);  add_v(1, I_SRAI, 1, 0, ST_EXI, 10, 0, 1, -1, SN);   wba(I_SRAI);
        fd(I_ADDIN, 0); add_v(1, I_ADDIN, 1, 0, ST_EXI, 0, 0, 1, -1, SN);   wba(I_ADDIN);
        fd(I_BEQ, 1);   add_v(1, I_BEQ, 1, 1, ST_BR, 1, 0, 0, -1, "011000--");
        fd(I_BNE, 1);   add_v(1, I_BNE, 1, 1, ST_BR, 1, 0, 0, -1, "010000--");
        fd(I_BLT, 0);   add_v(1, I_BLT, 1, 0, ST_BR, 15, 0, 0, -1, "011000--");
        fd(I_BGEU, 0);  add_v(1, I_BGEU, 1, 0, ST_BR, 12, 0, 0, -1, "010000--");
        fd(I_LW, 0);    add_v(1, I_LW, 1, 0, ST_MADR, 0, 0, 1, -1, SN);
        for (int k = 0; k < 3; k++) add_v(1, I_LW, 0, 0, ST_MRD, -1, -1, -1, -1, "0-000101");
        add_v(1, I_LW, 1, 0, ST_MRD, -1, -1, -1, -1, "0-000101");
        add_v(1, I_LW, 1, 0, ST_WBM, -1, -1, -1, 1, "0-0010--");
        fd(I_SW, 0);    add_v(1, I_SW, 1, 0, ST_MADR, 0, 0, 1, -1, SN);
        add_v(1, I_SW, 1, 0, ST_MWR, -1, -1, -1, -1, "0-000111");
        fd(I_JAL, 0);   add_v(1, I_JAL, 1, 0, ST_JAL, -1, -1, -1, 2, "011010--");
        fd(I_JALR, 0);  add_v(1, I_JALR, 1, 0, ST_JALR, 6, 0, 1, -1, SN);
        add_v(1, I_JALR, 1, 0, ST_JWB, -1, -1, -1, 2, "011010--");
        fd(I_LUI, 0);   add_v(1, I_LUI, 1, 0, ST_UIMM, 0, 3, 1, -1, SN);    wba(I_LUI);
        fd(I_AUIPC, 0); add_v(1, I_AUIPC, 1, 0, ST_UIMM, 0, 2, 1, -1, SN);  wba(I_AUIPC);
        for (int k = 0; k < 4; k++) add_v(1, I_ADD, 0, 0, ST_F, 0, 1, 2, -1, "0-000100");
        fd(I_ADD, 0);   add_v(1, I_ADD, 1, 0, ST_EXR, 0, 0, 0, -1, SN);     wba(I_ADD);
        fd(I_BBAD, 1);  add_v(1, I_BBAD, 1, 1, ST_BR, -1, -1, -1, -1, "010000--");
        for (int k = 0; k < 2; k++) add_v(1, I_BBAD, 1, 0, ST_TRAP, -1, -1, -1, -1, "1-0000--");
        rsts(I_ILL);
        fd(I_ILL, 0);
        for (int k = 0; k < 2; k++) add_v(1, I_ILL, 1, 0, ST_TRAP, -1, -1, -1, -1, "1-0000--");
        rsts(I_ADD);
        for (int k = 0; k < 5; k++) add_v(1, I_ADD, 0, 0, ST_F, 0, 1, 2, -1, "0-000100");
        for (int k = 0; k < 3; k++) add_v(1, I_ADD, 1, 0, ST_TRAP, -1, -1, -1, -1, "1-0000--");

        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("reset_outputs", {busy_state, alu_ctrl, a_sel, b_sel, wb_sel, 2'b00},
            16'h0000);
        chk("reset_strobes", {8'h00, strobes()}, 16'h0000);

        for (int k = 0; k < tv.size(); k++) begin
            rst_n     = tv[k].r;
            instr     = tv[k].i;
            mem_ready = tv[k].rdy;
            alu_flags = tv[k].fl;
            #1;
            n_run++;
            if (!match(tv[k])) begin
                n_fail++;
                $display("FAIL vec%0d: got st=%0d ctrl=%0d a=%0d b=%0d wb=%0d s=%b, expected st=%0d ctrl=%0d a=%0d b=%0d wb=%0d s=%s",
                         k, busy_state, alu_ctrl, a_sel, b_sel, wb_sel, strobes(),
                         tv[k].st, tv[k].ctrl, tv[k].a, tv[k].b, tv[k].wb, tv[k].s);
            end
            @(posedge clk); #1;
        end

        rst_n = 1'b0;
        instr = I_JAL;
        mem_ready = 1'b1;
        alu_flags = '0;
        #1;
        chk("trap_cleared", {11'd0, illegal, busy_state}, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("jal_strobes", {8'd0, busy_state, pc_write, reg_write, wb_sel}, {8'd0, 4'd11, 2'b11, 2'd2});
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset", {8'd0, busy_state, pc_write, reg_write, ir_write, mem_req},
            16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
